wb_rr_arbiter: RTL and testbench

- Shares one Wishbone slave port between NUM_M Wishbone masters, for example several bench BFMs or CPU/DMA agents in front of one generated register map.
- Round-robin arbitration, one transfer per grant.
- Per-transfer ack timeout so a dead slave cannot hang the bus.
- Sits between master-side Wishbone interfaces and a single slave's wb_* ports.

---
 rtl/wb_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port,
// one transfer per grant, with an ack timeout that forces completion.
module wb_rr_arbiter #(
  parameter int                NUM_M        = 2,
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                STRB_W       = DATA_W/8,
  parameter int                TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M*ADDR_W-1:0] m_adr,
  input  logic [NUM_M*DATA_W-1:0] m_dat_w,
  input  logic [NUM_M*STRB_W-1:0] m_sel,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M-1:0]    m_stb,
  input  logic [NUM_M-1:0]    m_cyc,
  output logic [DATA_W-1:0]   m_dat_r,
  output logic [NUM_M-1:0]    m_ack,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [STRB_W-1:0]   s_sel,
  output logic                s_we,
  output logic                s_stb,
  output logic                s_cyc,
  input  logic [DATA_W-1:0]   s_dat_r,
  input  logic                s_ack,
  output logic [NUM_M-1:0]    grant,
  output logic                timeout_o
);

  if (NUM_M < 2) begin : g_bad_num_m
    $error("wb_rr_arbiter: NUM_M must be >= 2");
  end

  localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TMO  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [LW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NUM_M-1:0] req;
  logic [LW-1:0]    win;
  logic             found;

  assign req   = m_cyc & m_stb;
  assign grant = grant_q;

  // Masters above the last winner first, then wrap to the low ones.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && req[i] && (LW'(i) > last_q)) begin
        found = 1'b1;
        win   = LW'(i);
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && req[i] && (LW'(i) <= last_q)) begin
        found = 1'b1;
        win   = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          grant_d = NUM_M'(1) << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (s_ack || !m_cyc[last_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
          state_d = S_TMO;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TMO: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_adr     = '0;
    s_dat_w   = '0;
    s_sel     = '0;
    s_we      = 1'b0;
    s_stb     = 1'b0;
    s_cyc     = 1'b0;
    m_ack     = '0;
    m_dat_r   = '0;
    timeout_o = 1'b0;
    unique case (state_q)
      S_BUSY: begin
        s_adr   = m_adr[last_q*ADDR_W +: ADDR_W];
        s_dat_w = m_dat_w[last_q*DATA_W +: DATA_W];
        s_sel   = m_sel[last_q*STRB_W +: STRB_W];
        s_we    = m_we[last_q];
        s_stb   = m_stb[last_q];
        s_cyc   = m_cyc[last_q];
        m_ack[last_q] = s_ack;
        m_dat_r = s_dat_r;
      end
      S_TMO: begin
        m_ack[last_q] = 1'b1;
        m_dat_r   = TIMEOUT_DATA;
        timeout_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: table of per-cycle vectors plus
// hand sequences for timeout, abort and mid-transfer reset.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_cyc = '0;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic            s_we, s_stb, s_cyc;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack = 1'b0;
  logic [N-1:0]    grant;
  logic            timeout_o;

  always #5 clk = ~clk;

  // Slave returns data tagged with the address it sees.
  assign s_dat_r = {16'hA5A5, s_adr};

  wb_rr_arbiter #(
    .NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW),
    .TIMEOUT(4), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(rst_n),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_we(m_we), .m_stb(m_stb), .m_cyc(m_cyc),
    .m_dat_r(m_dat_r), .m_ack(m_ack),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_dat_r(s_dat_r), .s_ack(s_ack),
    .grant(grant), .timeout_o(timeout_o)
  );

  logic [AW-1:0] ADR [N];
  logic [SW-1:0] SEL [N];
  logic [DW-1:0] WD  [N];

  typedef struct {
    logic          rst;
    logic [2:0]    cyc, stb, we;
    logic          ack;
    logic [2:0]    grant, mack;
    logic          scyc, sstb, swe;
    logic [AW-1:0] sadr;
    logic [SW-1:0] ssel;
    logic [DW-1:0] sdatw, datr;
    logic          tmo;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %h want %h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic add_idle(input logic rst, input logic [2:0] cyc,
                          input logic [2:0] stb, input logic [2:0] we);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = 1'b0;
    v.grant = '0; v.mack = '0; v.scyc = 1'b0; v.sstb = 1'b0;
    v.swe = 1'b0; v.sadr = '0; v.ssel = '0; v.sdatw = '0;
    v.datr = '0; v.tmo = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic add_busy(input int m, input logic [2:0] cyc,
                          input logic [2:0] stb, input logic [2:0] we,
                          input logic ack);
    vec_t v;
    v.rst = 1'b0; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack;
    v.grant = 3'(1 << m);
    v.mack  = ack ? 3'(1 << m) : 3'b000;
    v.scyc  = cyc[m]; v.sstb = stb[m]; v.swe = we[m];
    v.sadr  = ADR[m]; v.ssel = SEL[m]; v.sdatw = WD[m];
    v.datr  = {16'hA5A5, ADR[m]};
    v.tmo   = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] cyc, input logic [2:0] stb,
                       input logic [2:0] we, input logic ack);
    @(negedge clk);
    m_cyc = cyc; m_stb = stb; m_we = we; s_ack = ack;
    #1;
  endtask

  initial begin
    ADR[0] = 16'h0010; ADR[1] = 16'h0020; ADR[2] = 16'h0030;
    SEL[0] = 4'hF;     SEL[1] = 4'h3;     SEL[2] = 4'hC;
    WD[0]  = 32'h12345678; WD[1] = 32'h11111111; WD[2] = 32'h22222222;
    m_adr   = {ADR[2], ADR[1], ADR[0]};
    m_sel   = {SEL[2], SEL[1], SEL[0]};
    m_dat_w = {WD[2], WD[1], WD[0]};

    // single master write, ack two cycles after strobe
    add_idle(1'b1, 3'b000, 3'b000, 3'b000);
    add_idle(1'b0, 3'b001, 3'b001, 3'b001);
    add_busy(0, 3'b001, 3'b001, 3'b001, 1'b0);
    add_busy(0, 3'b001, 3'b001, 3'b001, 1'b0);
    add_busy(0, 3'b001, 3'b001, 3'b001, 1'b1);
    add_idle(1'b0, 3'b000, 3'b000, 3'b000);
    // contention from reset: order 0,1,2,0
    add_idle(1'b1, 3'b000, 3'b000, 3'b000);
    add_idle(1'b0, 3'b111, 3'b111, 3'b000);
    add_busy(0, 3'b111, 3'b111, 3'b000, 1'b1);
    add_idle(1'b0, 3'b111, 3'b111, 3'b000);
    add_busy(1, 3'b111, 3'b111, 3'b000, 1'b1);
    add_idle(1'b0, 3'b111, 3'b111, 3'b000);
    add_busy(2, 3'b111, 3'b111, 3'b000, 1'b1);
    add_idle(1'b0, 3'b111, 3'b111, 3'b000);
    add_busy(0, 3'b111, 3'b111, 3'b000, 1'b1);
    // M1 served, then M0+M1 request: M0 wins
    add_idle(1'b0, 3'b010, 3'b010, 3'b000);
    add_busy(1, 3'b010, 3'b010, 3'b000, 1'b1);
    add_idle(1'b0, 3'b011, 3'b011, 3'b000);
    add_busy(0, 3'b011, 3'b011, 3'b000, 1'b0);
    add_busy(0, 3'b011, 3'b011, 3'b000, 1'b1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = !tbl[i].rst;
      m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      m_we  = tbl[i].we;  s_ack = tbl[i].ack;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("v%0d m_ack", i), 32'(m_ack), 32'(tbl[i].mack));
      chk($sformatf("v%0d s_cyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
      chk($sformatf("v%0d s_stb", i), 32'(s_stb), 32'(tbl[i].sstb));
      chk($sformatf("v%0d s_we", i), 32'(s_we), 32'(tbl[i].swe));
      chk($sformatf("v%0d s_adr", i), 32'(s_adr), 32'(tbl[i].sadr));
      chk($sformatf("v%0d s_sel", i), 32'(s_sel), 32'(tbl[i].ssel));
      chk($sformatf("v%0d s_dat_w", i), s_dat_w, tbl[i].sdatw);
      chk($sformatf("v%0d m_dat_r", i), m_dat_r, tbl[i].datr);
      chk($sformatf("v%0d timeout", i), 32'(timeout_o), 32'(tbl[i].tmo));
    end

    // timeout: M2 reads, slave silent
    drive(3'b100, 3'b100, 3'b000, 1'b0);
    chk("tmo arb grant", 32'(grant), 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(3'b100, 3'b100, 3'b000, 1'b0);
      chk($sformatf("tmo busy%0d grant", k), 32'(grant), 32'h4);
      chk($sformatf("tmo busy%0d s_cyc", k), 32'(s_cyc), 32'h1);
      chk($sformatf("tmo busy%0d m_ack", k), 32'(m_ack), 32'h0);
      chk($sformatf("tmo busy%0d pulse", k), 32'(timeout_o), 32'h0);
    end
    drive(3'b100, 3'b100, 3'b000, 1'b0);
    chk("tmo m_ack", 32'(m_ack), 32'h4);
    chk("tmo m_dat_r", m_dat_r, 32'hDEADBEEF);
    chk("tmo pulse", 32'(timeout_o), 32'h1);
    chk("tmo s_cyc", 32'(s_cyc), 32'h0);
    chk("tmo s_stb", 32'(s_stb), 32'h0);
    drive(3'b000, 3'b000, 3'b000, 1'b0);
    chk("tmo after pulse", 32'(timeout_o), 32'h0);
    chk("tmo after grant", 32'(grant), 32'h0);
    drive(3'b000, 3'b000, 3'b000, 1'b1);
    chk("late ack m_ack", 32'(m_ack), 32'h0);
    drive(3'b000, 3'b000, 3'b000, 1'b0);

    // abort: M0 drops cyc, M1 pending
    drive(3'b011, 3'b011, 3'b000, 1'b0);
    chk("abort arb grant", 32'(grant), 32'h0);
    drive(3'b011, 3'b011, 3'b000, 1'b0);
    chk("abort busy grant", 32'(grant), 32'h1);
    chk("abort busy s_cyc", 32'(s_cyc), 32'h1);
    drive(3'b010, 3'b010, 3'b000, 1'b0);
    chk("abort drop s_cyc", 32'(s_cyc), 32'h0);
    chk("abort drop m_ack", 32'(m_ack), 32'h0);
    drive(3'b010, 3'b010, 3'b000, 1'b0);
    chk("abort idle grant", 32'(grant), 32'h0);
    chk("abort idle m_ack", 32'(m_ack), 32'h0);
    drive(3'b010, 3'b010, 3'b000, 1'b0);
    chk("abort M1 grant", 32'(grant), 32'h2);
    drive(3'b000, 3'b000, 3'b000, 1'b1);
    chk("ack beats abort", 32'(m_ack), 32'h2);
    drive(3'b000, 3'b000, 3'b000, 1'b0);
    chk("post ack grant", 32'(grant), 32'h0);

    // reset in the middle of an M0 transfer
    drive(3'b011, 3'b011, 3'b000, 1'b0);
    drive(3'b011, 3'b011, 3'b000, 1'b0);
    chk("rst pre grant", 32'(grant), 32'h1);
    chk("rst pre s_cyc", 32'(s_cyc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async s_cyc", 32'(s_cyc), 32'h0);
    chk("rst async s_stb", 32'(s_stb), 32'h0);
    chk("rst async grant", 32'(grant), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release grant", 32'(grant), 32'h0);
    drive(3'b011, 3'b011, 3'b000, 1'b0);
    chk("rst M0 first", 32'(grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
